// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding, default bitmap geometry and width helpers
// for cmp_align_scorer and its leading-zero counter.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Geometry of the existing 24x64 glyph format.
    localparam int DEF_ROW_W = 24;
    localparam int DEF_ROWS  = 64;

    // Width of lshift: must hold 0..row_w (row_w means "no set pixel").
    function automatic int lsh_w(input int row_w);
        return $clog2(row_w + 1);
    endfunction

    // Width of dshift: must hold 0..rows (rows means "empty image").
    function automatic int dsh_w(input int rows);
        return $clog2(rows + 1);
    endfunction

    // Width of mismatch: must hold every pixel differing.
    function automatic int mis_w(input int row_w, input int rows);
        return $clog2(row_w * rows + 1);
    endfunction

    // Width of the row counter: indexes 0..rows-1.
    function automatic int cnt_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/cmp_lzc.sv
// cmp_lzc: combinational leading-zero counter. Counts zeros from bit W-1
// downward; an all-zero input returns W.
module cmp_lzc import cmp_pkg::*; #(
    parameter int W = DEF_ROW_W
) (
    input  logic [W-1:0]          din,
    output logic [lsh_w(W)-1:0]   count
);

    localparam int CW = lsh_w(W);

    // Scan from LSB to MSB so the highest set bit makes the final assignment.
    always_comb begin
        // NOTE: count gets a default before the loop so every path assigns it and no latch is inferred.
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/cmp_align_scorer.sv
// cmp_align_scorer: buffers a candidate glyph bitmap, finds its top (dshift)
// and left (lshift) boundaries while loading, then scores an aligned
// comparison against a streamed reference template.
// Optional feature macro: CMP_EARLY_ABORT_EN (stop once mismatch exceeds
// ABORT_THRESH); the default build consumes every template row.
module cmp_align_scorer import cmp_pkg::*; #(
    parameter int ROW_W        = DEF_ROW_W,
    parameter int ROWS         = DEF_ROWS,
    parameter int ABORT_THRESH = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          img_valid,
    output logic                          img_ready,
    input  logic [ROW_W-1:0]              img_row,
    input  logic                          tpl_valid,
    output logic                          tpl_ready,
    input  logic [ROW_W-1:0]              tpl_row,
    output logic                          busy,
    output logic                          done,
    output logic                          empty,
    output logic                          aborted,
    output logic [lsh_w(ROW_W)-1:0]       lshift,
    output logic [dsh_w(ROWS)-1:0]        dshift,
    output logic [mis_w(ROW_W, ROWS)-1:0] mismatch
);

    localparam int LSW = lsh_w(ROW_W);
    localparam int DSW = dsh_w(ROWS);
    localparam int MW  = mis_w(ROW_W, ROWS);
    localparam int CW  = cnt_w(ROWS);
    localparam int SW  = DSW + 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [ROW_W-1:0] buffer [ROWS];
    logic [LSW-1:0]   row_lzc;
    logic [SW-1:0]    src;
    logic [ROW_W-1:0] aligned;
    logic [ROW_W-1:0] diff;
    logic [MW-1:0]    pop;
    logic [MW-1:0]    mismatch_next;
    logic             img_fire;
    logic             tpl_fire;
    logic             last_row;
    logic             abort_hit;

    assign img_fire = img_ready && img_valid;
    assign tpl_fire = tpl_ready && tpl_valid;
    assign last_row = (cnt == CW'(ROWS - 1));

    cmp_lzc #(.W(ROW_W)) u_lzc (
        .din   (img_row),
        .count (row_lzc)
    );

    // Pick buffered row r+dshift, left-align it and count differing pixels.
    always_comb begin
        src     = {1'b0, dshift} + SW'(cnt);
        aligned = '0;
        if (src < SW'(ROWS)) begin
            aligned = buffer[CW'(src)] << lshift;
        end
        diff = aligned ^ tpl_row;
        pop  = '0;
        for (int i = 0; i < ROW_W; i++) begin
            pop = pop + MW'(diff[i]);
        end
        mismatch_next = mismatch + pop;
    end

`ifdef CMP_EARLY_ABORT_EN
    assign abort_hit = tpl_fire && (int'(mismatch_next) > ABORT_THRESH);
`else
    logic unused_abort_thresh;
    assign abort_hit           = 1'b0;
    assign unused_abort_thresh = ABORT_THRESH[0];
`endif

    // State register; rst wins over any in-flight job.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (img_fire && last_row) state_next = CMP;
            CMP:     if (tpl_fire && (last_row || abort_hit)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        img_ready = 1'b0;
        tpl_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                img_ready = 1'b1;
                busy      = 1'b1;
            end
            CMP: begin
                tpl_ready = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Row counter, boundary search and mismatch accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            lshift   <= '0;
            dshift   <= '0;
            empty    <= 1'b0;
            mismatch <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        mismatch <= '0;
                        lshift   <= LSW'(ROW_W);
                        dshift   <= DSW'(ROWS);
                        empty    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (img_fire) begin
                        cnt <= last_row ? '0 : cnt + 1'b1;
                        if (img_row != '0) begin
                            if (row_lzc < lshift) lshift <= row_lzc;
                            if (empty) begin
                                dshift <= DSW'(cnt);
                                empty  <= 1'b0;
                            end
                        end
                    end
                end
                CMP: begin
                    if (tpl_fire) begin
                        cnt      <= last_row ? '0 : cnt + 1'b1;
                        mismatch <= mismatch_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Image row buffer, filled in LOAD order.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; LOAD rewrites every entry before CMP reads any.
        if (img_fire) begin
            buffer[cnt] <= img_row;
        end
    end

`ifdef CMP_EARLY_ABORT_EN
    // Sticky abort flag, cleared when the next job starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted <= 1'b0;
        end else if (state == IDLE && start) begin
            aborted <= 1'b0;
        end else if (state == CMP && abort_hit) begin
            aborted <= 1'b1;
        end
    end
`else
    assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_align_scorer.sv
// tb_cmp_align_scorer: scoreboard bench for cmp_align_scorer at ROW_W=8,
// ROWS=4. Build with CMP_EARLY_ABORT_EN defined to exercise early abort.
module tb_cmp_align_scorer;

    localparam int ROW_W        = 8;
    localparam int ROWS         = 4;
    localparam int ABORT_THRESH = 3;
`ifdef CMP_EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef logic [ROW_W-1:0] row_t;
    typedef row_t rows_t [ROWS];
    typedef struct {
        logic [3:0] ls;
        logic [2:0] ds;
        logic       empty;
        logic       aborted;
        logic [5:0] mis;
        int         nrows;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       img_valid;
    logic       img_ready;
    row_t       img_row;
    logic       tpl_valid;
    logic       tpl_ready;
    row_t       tpl_row;
    logic       busy;
    logic       done;
    logic       empty;
    logic       aborted;
    logic [3:0] lshift;
    logic [2:0] dshift;
    logic [5:0] mismatch;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cmp_align_scorer #(
        .ROW_W        (ROW_W),
        .ROWS         (ROWS),
        .ABORT_THRESH (ABORT_THRESH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .img_valid (img_valid),
        .img_ready (img_ready),
        .img_row   (img_row),
        .tpl_valid (tpl_valid),
        .tpl_ready (tpl_ready),
        .tpl_row   (tpl_row),
        .busy      (busy),
        .done      (done),
        .empty     (empty),
        .aborted   (aborted),
        .lshift    (lshift),
        .dshift    (dshift),
        .mismatch  (mismatch)
    );

    // Reference model: boundary search by scanning pixels, then aligned compare.
    function automatic exp_t model(input rows_t img, input rows_t tpl);
        exp_t e;
        row_t al;
        int   lz;
        e.ls = 4'd8; e.ds = 3'd4; e.empty = 1'b1; e.aborted = 1'b0; e.mis = '0; e.nrows = ROWS;
        for (int r = 0; r < ROWS; r++) begin
            if (img[r] != '0) begin
                if (e.empty) begin
                    e.ds    = 3'(r);
                    e.empty = 1'b0;
                end
                lz = 0;
                while (lz < ROW_W && !img[r][ROW_W-1-lz]) lz++;
                if (lz < int'(e.ls)) e.ls = 4'(lz);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            al = (r + int'(e.ds) < ROWS) ? row_t'(img[r + int'(e.ds)] << e.ls) : '0;
            e.mis = e.mis + 6'($countones(al ^ tpl[r]));
            if (ABORT_EN && int'(e.mis) > ABORT_THRESH) begin
                e.aborted = 1'b1;
                e.nrows   = r + 1;
                break;
            end
        end
        return e;
    endfunction

    task automatic start_job();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_img(input rows_t img, input bit gaps);
        int i = 0;
        int n = 0;
        bit fire;
        while (i < ROWS && n < 100) begin
            img_valid = !(gaps && n[0]);
            img_row   = img[i];
            @(negedge clk);
            fire = img_valid && img_ready;
            @(posedge clk); #1;
            if (fire) i++;
            n++;
        end
        img_valid = 1'b0;
        img_row   = '0;
        checks++;
        if (i != ROWS) begin
            failures++;
            $display("FAIL img_accept: accepted %0d rows, required %0d", i, ROWS);
        end
    endtask

    // Sends nrows template rows; pulses start alongside row start_row (-1: never).
    task automatic drive_tpl(input rows_t tpl, input int nrows, input int start_row);
        int i = 0;
        int n = 0;
        bit fire;
        while (i < nrows && n < 100) begin
            tpl_valid = 1'b1;
            tpl_row   = tpl[i];
            start     = (i == start_row);
            @(negedge clk);
            fire = tpl_ready;
            @(posedge clk); #1;
            if (fire) i++;
            n++;
        end
        tpl_valid = 1'b0;
        tpl_row   = '0;
        start     = 1'b0;
        checks++;
        if (i != nrows) begin
            failures++;
            $display("FAIL tpl_accept: accepted %0d rows, required %0d", i, nrows);
        end
    endtask

    // Waits for done, pops the scoreboard and scores the result and pulse width.
    task automatic wait_and_score(input string name, output int waited);
        exp_t e;
        bit   seen = 1'b0;
        waited = 0;
        while (!seen && waited < 64) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, waited);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: done seen with no expected result queued", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (lshift !== e.ls) begin
                failures++;
                $display("FAIL %s_lshift: got %0d, expected %0d", name, lshift, e.ls);
            end
            checks++;
            if (dshift !== e.ds) begin
                failures++;
                $display("FAIL %s_dshift: got %0d, expected %0d", name, dshift, e.ds);
            end
            checks++;
            if (empty !== e.empty) begin
                failures++;
                $display("FAIL %s_empty: got %b, expected %b", name, empty, e.empty);
            end
            checks++;
            if (aborted !== e.aborted) begin
                failures++;
                $display("FAIL %s_aborted: got %b, expected %b", name, aborted, e.aborted);
            end
            checks++;
            if (mismatch !== e.mis) begin
                failures++;
                $display("FAIL %s_mismatch: got %0d, expected %0d", name, mismatch, e.mis);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_at_done: got %b, expected 0", name, busy);
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_width: done still %b one cycle later, expected 0", name, done);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; img_valid = 1'b0; tpl_valid = 1'b0;
        img_row = '0; tpl_row = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({img_ready, tpl_ready, busy, done, empty, aborted} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: rdy/tpl/busy/done/empty/abort=%b, expected 000000",
                     {img_ready, tpl_ready, busy, done, empty, aborted});
        end
        checks++;
        if (lshift !== 4'd0) begin failures++; $display("FAIL reset_lshift: got %0d, expected 0", lshift); end
        checks++;
        if (dshift !== 3'd0) begin failures++; $display("FAIL reset_dshift: got %0d, expected 0", dshift); end
        checks++;
        if (mismatch !== 6'd0) begin failures++; $display("FAIL reset_mismatch: got %0d, expected 0", mismatch); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        rows_t img;
        rows_t tpl;
        exp_t  e;
        int    w;
        // Rows 0,1 blank; 0x0C has 4 leading zeros, 0x30 has 2 -> dshift=2, lshift=2.
        // Aligned rows are {0x30, 0xC0, 0x00, 0x00}.
        img = '{8'h00, 8'h00, 8'h0C, 8'h30};
        tpl = '{8'h30, 8'hC0, 8'h00, 8'h00};
        sb.push_back('{ls: 4'd2, ds: 3'd2, empty: 1'b0, aborted: 1'b0, mis: 6'd0, nrows: 4});
        start_job();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b after start, expected 1", busy); end
        @(posedge clk); #1;
        drive_img(img, 1'b0);
        drive_tpl(tpl, ROWS, -1);
        wait_and_score("basic", w);
        checks++;
        if (w != 0) begin failures++; $display("FAIL basic_latency: done %0d cycles late, expected 0", w); end

        // Swapped template rows: 0x30^0xC0 twice gives 8 differing pixels.
        tpl = '{8'hC0, 8'h30, 8'h00, 8'h00};
        e = model(img, tpl);
        sb.push_back(e);
        start_job();
        drive_img(img, 1'b0);
        drive_tpl(tpl, e.nrows, -1);
        wait_and_score("swapped", w);
    endtask

    task automatic test_empty();
        rows_t img;
        rows_t tpl;
        exp_t  e;
        int    w;
        // Nothing to align: mismatch is the template popcount (8 + 1 without abort).
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        tpl = '{8'hFF, 8'h01, 8'h00, 8'h00};
        e = model(img, tpl);
        sb.push_back(e);
        start_job();
        drive_img(img, 1'b0);
        drive_tpl(tpl, e.nrows, -1);
        wait_and_score("empty", w);
    endtask

    task automatic test_stall();
        rows_t img;
        int    w;
        img = '{8'h80, 8'h40, 8'h20, 8'h10};
        for (int pass = 0; pass < 2; pass++) begin
            sb.push_back('{ls: 4'd0, ds: 3'd0, empty: 1'b0, aborted: 1'b0, mis: 6'd0, nrows: 4});
            start_job();
            drive_img(img, pass == 0);
            drive_tpl(img, ROWS, -1);
            wait_and_score(pass == 0 ? "stalled" : "streamed", w);
        end
    endtask

    task automatic test_reset_mid();
        rows_t img;
        rows_t tpl;
        int    w;
        img = '{8'h00, 8'h00, 8'h0C, 8'h30};
        tpl = '{8'h30, 8'hC0, 8'h00, 8'h00};
        start_job();
        drive_img(img, 1'b0);
        tpl_valid = 1'b1;
        tpl_row   = tpl[0];
        @(posedge clk); #1;
        tpl_row = tpl[1];
        rst     = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        tpl_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({img_ready, tpl_ready, busy, done, empty, aborted} !== 6'b0) begin
            failures++;
            $display("FAIL midrst_flags: rdy/tpl/busy/done/empty/abort=%b, expected 000000",
                     {img_ready, tpl_ready, busy, done, empty, aborted});
        end
        checks++;
        if ({lshift, dshift, mismatch} !== 13'd0) begin
            failures++;
            $display("FAIL midrst_results: lshift=%0d dshift=%0d mismatch=%0d, expected all 0",
                     lshift, dshift, mismatch);
        end
        @(posedge clk); #1;
        sb.push_back('{ls: 4'd2, ds: 3'd2, empty: 1'b0, aborted: 1'b0, mis: 6'd0, nrows: 4});
        start_job();
        drive_img(img, 1'b0);
        drive_tpl(tpl, ROWS, -1);
        wait_and_score("after_rst", w);
    endtask

    task automatic test_start_in_cmp();
        rows_t img;
        int    w;
        int    pulses = 0;
        int    busy_cycles = 0;
        img = '{8'h80, 8'h40, 8'h20, 8'h10};
        sb.push_back('{ls: 4'd0, ds: 3'd0, empty: 1'b0, aborted: 1'b0, mis: 6'd0, nrows: 4});
        start_job();
        drive_img(img, 1'b0);
        drive_tpl(img, ROWS, 1);
        wait_and_score("start_in_cmp", w);
        repeat (10) begin
            @(negedge clk);
            pulses      += int'(done);
            busy_cycles += int'(busy);
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL extra_done: %0d extra done pulses, expected 0", pulses); end
        checks++;
        if (busy_cycles != 0) begin failures++; $display("FAIL restart: busy for %0d cycles, expected 0", busy_cycles); end
    endtask

    task automatic test_back_to_back();
        rows_t img;
        rows_t tpl;
        exp_t  e;
        int    w;
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < ROWS; r++) begin
                img[r] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                tpl[r] = 8'($urandom);
            end
            e = model(img, tpl);
            sb.push_back(e);
            start_job();
            drive_img(img, j[0]);
            drive_tpl(tpl, e.nrows, -1);
            wait_and_score("random", w);
        end
    endtask

`ifdef CMP_EARLY_ABORT_EN
    task automatic test_abort();
        rows_t img;
        rows_t tpl;
        int    w;
        int    ready_cycles = 0;
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        tpl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sb.push_back('{ls: 4'd8, ds: 3'd4, empty: 1'b1, aborted: 1'b1, mis: 6'd8, nrows: 1});
        start_job();
        drive_img(img, 1'b0);
        drive_tpl(tpl, 1, -1);
        tpl_valid = 1'b1;
        tpl_row   = 8'hFF;
        wait_and_score("abort", w);
        checks++;
        if (w != 0) begin failures++; $display("FAIL abort_latency: done %0d cycles late, expected 0", w); end
        repeat (4) begin
            @(negedge clk);
            ready_cycles += int'(tpl_ready);
            @(posedge clk); #1;
        end
        tpl_valid = 1'b0;
        checks++;
        if (ready_cycles != 0) begin failures++; $display("FAIL abort_ready: tpl_ready high %0d cycles, expected 0", ready_cycles); end
        checks++;
        if (aborted !== 1'b1) begin failures++; $display("FAIL abort_hold: aborted=%b, expected 1 until start", aborted); end
        tpl = '{8'h00, 8'h00, 8'h00, 8'h00};
        sb.push_back('{ls: 4'd8, ds: 3'd4, empty: 1'b1, aborted: 1'b0, mis: 6'd0, nrows: 4});
        start_job();
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0) begin failures++; $display("FAIL abort_clear: aborted=%b after start, expected 0", aborted); end
        @(posedge clk); #1;
        drive_img(img, 1'b0);
        drive_tpl(tpl, ROWS, -1);
        wait_and_score("post_abort", w);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_stall();
        test_reset_mid();
        test_start_in_cmp();
        test_back_to_back();
`ifdef CMP_EARLY_ABORT_EN
        test_abort();
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expected results never produced, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
